// File: rtl/histo_equalizer_if.sv
// Pixel and cumulative-histogram bundle for histo_equalizer.
// iBypass exists only when HEQ_BYPASS_EN is defined.
interface histo_equalizer_if #(
    parameter int CUM_W = 20
);
    logic             iFval;
    logic             iDval;
    logic [11:0]      iGrey;
    logic             iCum_Valid;
    logic [7:0]       iCum_Addr;
    logic [CUM_W-1:0] iCum_Data;
    logic             iCum_Last;
    logic [11:0]      oEq_Grey;
    logic             oEq_Dval;
    logic             oLut_Valid;
    logic             oBusy;
`ifdef HEQ_BYPASS_EN
    logic             iBypass;

    modport master (
        output iFval, iDval, iGrey, iCum_Valid, iCum_Addr, iCum_Data, iCum_Last, iBypass,
        input  oEq_Grey, oEq_Dval, oLut_Valid, oBusy
    );
    modport slave (
        input  iFval, iDval, iGrey, iCum_Valid, iCum_Addr, iCum_Data, iCum_Last, iBypass,
        output oEq_Grey, oEq_Dval, oLut_Valid, oBusy
    );
`else
    modport master (
        output iFval, iDval, iGrey, iCum_Valid, iCum_Addr, iCum_Data, iCum_Last,
        input  oEq_Grey, oEq_Dval, oLut_Valid, oBusy
    );
    modport slave (
        input  iFval, iDval, iGrey, iCum_Valid, iCum_Addr, iCum_Data, iCum_Last,
        output oEq_Grey, oEq_Dval, oLut_Valid, oBusy
    );
`endif
endinterface

// File: rtl/histo_equalizer.sv
// histo_equalizer: normalises the streamed cumulative histogram into a double-buffered
// 256x12 LUT and remaps live grey pixels through it. Optional macro: HEQ_BYPASS_EN.
module histo_equalizer #(
    parameter int BIN_SHIFT = 4,
    parameter int CUM_W     = 20,
    parameter int OUT_MAX   = 4095
) (
    input  logic             iPclk,
    input  logic             iRST,
    histo_equalizer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RD   = 3'd2,
        ST_MUL  = 3'd3,
        ST_DIV  = 3'd4,
        ST_WR   = 3'd5
    } state_t;

    state_t           state_r, state_s;
    logic [CUM_W-1:0] stage_mem [0:255];
    logic [11:0]      lut_mem [0:511];
    logic [CUM_W-1:0] pix_cnt_r, total_r, div_total_r, stage_q_r;
    logic             fval_d_r, active_r, pending_r, lut_valid_r, busy_r;
    logic [7:0]       idx_r, bin_s;
    logic [31:0]      num_s, trial_s, rem_r;
    logic [3:0]       cnt_r;
    logic [11:0]      quot_r, lut_q_r, grey_d1_r, eq_grey_r;
    logic             rise_s, fall_s, swap_s, pix_s, rd_bank_s, sat_s, zero_s, lut_use_s;
    logic             dval_d1_r, sel_d1_r, eq_dval_r;

    assign rise_s    = bus.iFval & ~fval_d_r;
    assign fall_s    = ~bus.iFval & fval_d_r;
    assign pix_s     = bus.iFval & bus.iDval;
    // The inactive bank is only written in RD..WR, so a swap is held off until then.
    assign swap_s    = rise_s & pending_r & ((state_r == ST_IDLE) | (state_r == ST_LOAD));
    assign rd_bank_s = swap_s ? ~active_r : active_r;
    assign bin_s     = 8'(bus.iGrey >> BIN_SHIFT);
    assign num_s     = 32'(stage_q_r) * 32'(OUT_MAX);
    assign trial_s   = 32'(div_total_r) << cnt_r;
    assign sat_s     = (num_s >= (32'(div_total_r) << 4'd12));
    assign zero_s    = (div_total_r == {CUM_W{1'b0}});
`ifdef HEQ_BYPASS_EN
    assign lut_use_s = (lut_valid_r | swap_s) & ~bus.iBypass;
`else
    assign lut_use_s = lut_valid_r | swap_s;
`endif

    assign bus.oEq_Grey   = eq_grey_r;
    assign bus.oEq_Dval   = eq_dval_r;
    assign bus.oLut_Valid = lut_valid_r;
    assign bus.oBusy      = busy_r;

    // Build FSM state register with registered busy flag
    always_ff @(posedge iPclk) begin
        if (iRST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Build FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: if (bus.iCum_Valid) state_s = ST_LOAD; else state_s = ST_IDLE;
            ST_LOAD: if (bus.iCum_Valid && bus.iCum_Last) state_s = ST_RD; else state_s = ST_LOAD;
            ST_RD:   state_s = ST_MUL;
            ST_MUL:  if (zero_s || sat_s) state_s = ST_WR; else state_s = ST_DIV;
            ST_DIV:  if (cnt_r == 4'd0) state_s = ST_WR; else state_s = ST_DIV;
            ST_WR:   if (idx_r == 8'hFF) state_s = ST_IDLE; else state_s = ST_RD;
            default: state_s = ST_IDLE;
        endcase
    end

    // Normalisation datapath: bin index, restoring divider, pending-swap flag
    always_ff @(posedge iPclk) begin
        if (iRST) begin
            idx_r       <= 8'd0;
            div_total_r <= {CUM_W{1'b0}};
            rem_r       <= 32'd0;
            cnt_r       <= 4'd0;
            quot_r      <= 12'd0;
            pending_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    // Divisor is frozen here so a frame ending mid-build cannot disturb it.
                    if (bus.iCum_Valid && bus.iCum_Last) begin
                        idx_r       <= 8'd0;
                        div_total_r <= total_r;
                    end
                end
                ST_MUL: begin
                    rem_r <= num_s;
                    cnt_r <= 4'd11;
                    if (zero_s)     quot_r <= 12'({4'd0, idx_r} << BIN_SHIFT);
                    else if (sat_s) quot_r <= 12'(OUT_MAX);
                    else            quot_r <= 12'd0;
                end
                ST_DIV: begin
                    if (rem_r >= trial_s) begin
                        rem_r  <= rem_r - trial_s;
                        quot_r <= {quot_r[10:0], 1'b1};
                    end else begin
                        quot_r <= {quot_r[10:0], 1'b0};
                    end
                    cnt_r <= cnt_r - 4'd1;
                end
                ST_WR:   idx_r <= idx_r + 8'd1;
                default: idx_r <= idx_r;
            endcase
            if ((state_r == ST_WR) && (idx_r == 8'hFF)) pending_r <= 1'b1;
            else if (swap_s)                            pending_r <= 1'b0;
        end
    end

    // Staging RAM: written while loading, read with one cycle latency
    always_ff @(posedge iPclk) begin
        if (((state_r == ST_IDLE) || (state_r == ST_LOAD)) && bus.iCum_Valid && !iRST)
            stage_mem[bus.iCum_Addr] <= bus.iCum_Data;
        stage_q_r <= stage_mem[idx_r];
    end

    // LUT banks: FSM writes the inactive bank, pixel path reads the active one
    always_ff @(posedge iPclk) begin
        if ((state_r == ST_WR) && !iRST)
            lut_mem[{~active_r, idx_r}] <= quot_r;
        lut_q_r <= lut_mem[{rd_bank_s, bin_s}];
    end

    // Frame tracking: pixel count, total, bank swap
    always_ff @(posedge iPclk) begin
        if (iRST) begin
            fval_d_r    <= 1'b0;
            pix_cnt_r   <= {CUM_W{1'b0}};
            total_r     <= {CUM_W{1'b0}};
            active_r    <= 1'b0;
            lut_valid_r <= 1'b0;
        end else begin
            fval_d_r <= bus.iFval;
            if (fall_s) begin
                total_r   <= pix_cnt_r;
                pix_cnt_r <= {CUM_W{1'b0}};
            end else if (pix_s && (pix_cnt_r != {CUM_W{1'b1}})) begin
                pix_cnt_r <= pix_cnt_r + {{(CUM_W-1){1'b0}}, 1'b1};
            end
            if (swap_s) begin
                active_r    <= ~active_r;
                lut_valid_r <= 1'b1;
            end
        end
    end

    // Two-stage pixel pipeline; the LUT/passthrough choice travels with each pixel
    always_ff @(posedge iPclk) begin
        if (iRST) begin
            grey_d1_r <= 12'd0;
            dval_d1_r <= 1'b0;
            sel_d1_r  <= 1'b0;
            eq_grey_r <= 12'd0;
            eq_dval_r <= 1'b0;
        end else begin
            grey_d1_r <= bus.iGrey;
            dval_d1_r <= pix_s;
            sel_d1_r  <= lut_use_s;
            eq_grey_r <= sel_d1_r ? lut_q_r : grey_d1_r;
            eq_dval_r <= dval_d1_r;
        end
    end
endmodule
